fully_connected_mac: RTL

Sequential multiply-accumulate engine for the fully connected layer. It sits directly downstream of the fully connected weight memory. On a start pulse it captures the flattened activation vector, the weight vector and a bias. It then accumulates one signed product per cycle and presents the single neuron result on a valid/ready output handshake. The weight memory can be rewritten as soon as `start` has been accepted.

---
 rtl/fully_connected_mac_if.sv | 25 ++
 rtl/fully_connected_mac.sv | 132 +++++++++++++
 2 files changed

// File: rtl/fully_connected_mac_if.sv
// Handshake and operand bundle between a requester and the fully connected MAC engine.
interface fully_connected_mac_if #(
    parameter int FLATTENED_LENGTH          = 50,
    parameter int FULLYCONNECTED_DATA_WIDTH = 8,
    parameter int ACCUM_WIDTH               = 24
);
    logic                                                      start;
    logic [FLATTENED_LENGTH-1:0][FULLYCONNECTED_DATA_WIDTH-1:0] flattened_input;
    logic [FLATTENED_LENGTH-1:0][FULLYCONNECTED_DATA_WIDTH-1:0] fullyconnected_weights;
    logic [FULLYCONNECTED_DATA_WIDTH-1:0]                      fullyconnected_bias;
    logic                                                      busy;
    logic                                                      out_valid;
    logic                                                      out_ready;
    logic [ACCUM_WIDTH-1:0]                                    fc_result;

    modport master (
        output start, flattened_input, fullyconnected_weights, fullyconnected_bias, out_ready,
        input  busy, out_valid, fc_result
    );

    modport slave (
        input  start, flattened_input, fullyconnected_weights, fullyconnected_bias, out_ready,
        output busy, out_valid, fc_result
    );
endinterface

// File: rtl/fully_connected_mac.sv
// Sequential signed multiply-accumulate for one fully connected neuron: captures operands on start,
// performs one MAC per cycle, then holds the (optionally ReLU-clamped) result on a valid/ready handshake.
module fully_connected_mac #(
    parameter int FLATTENED_LENGTH          = 50,
    parameter int FULLYCONNECTED_DATA_WIDTH = 8,
    parameter int ACCUM_WIDTH               = 24,
    parameter int APPLY_RELU                = 0
) (
    input logic                   clk,
    input logic                   rst,
    fully_connected_mac_if.slave  bus
);
    localparam int N     = FLATTENED_LENGTH;
    localparam int DW    = FULLYCONNECTED_DATA_WIDTH;
    localparam int AW    = ACCUM_WIDTH;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [N-1:0][DW-1:0]      act_q, wgt_q;
    logic [IDX_W-1:0]          idx_q;
    logic [AW-1:0]             acc_q;
    logic [AW-1:0]             result_q;
    logic                      valid_q;
    logic                      busy_q;

    logic signed [2*DW-1:0]    prod_s;
    logic [AW-1:0]             acc_sum_s;
    logic                      capture_s, mac_s, last_s, handshake_s;

    function automatic logic [AW-1:0] relu_clamp(input logic [AW-1:0] v);
        if ((APPLY_RELU != 0) && v[AW-1]) begin
            return '0;
        end else begin
            return v;
        end
    endfunction

    // Full-precision signed product, sign-extended into the accumulator width
    assign prod_s    = $signed(act_q[idx_q]) * $signed(wgt_q[idx_q]);
    assign acc_sum_s = acc_q + {{(AW-2*DW){prod_s[2*DW-1]}}, prod_s};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_MAC;
                else           state_d = ST_IDLE;
            end
            ST_MAC: begin
                if (idx_q == IDX_W'(N-1)) state_d = ST_DONE;
                else                      state_d = ST_MAC;
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
                else               state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Per-state datapath strobes
    always_comb begin
        capture_s   = 1'b0;
        mac_s       = 1'b0;
        last_s      = 1'b0;
        handshake_s = 1'b0;
        case (state_q)
            ST_IDLE: capture_s   = bus.start;
            ST_MAC: begin
                mac_s  = 1'b1;
                last_s = (idx_q == IDX_W'(N-1));
            end
            ST_DONE: handshake_s = valid_q && bus.out_ready;
            default: capture_s   = 1'b0;
        endcase
    end

    // Operand capture, accumulation and result/handshake registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_q    <= '0;
            wgt_q    <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            busy_q <= (state_d != ST_IDLE);
            if (capture_s) begin
                act_q <= bus.flattened_input;
                wgt_q <= bus.fullyconnected_weights;
                acc_q <= {{(AW-DW){bus.fullyconnected_bias[DW-1]}}, bus.fullyconnected_bias};
                idx_q <= '0;
            end else if (mac_s) begin
                acc_q <= acc_sum_s;
                // idx returns to 0 after the last term so it never leaves the operand range
                idx_q <= last_s ? '0 : idx_q + IDX_W'(1);
            end else begin
                idx_q <= idx_q;
            end
            if (last_s) begin
                result_q <= relu_clamp(acc_sum_s);
                valid_q  <= 1'b1;
            end else if (handshake_s) begin
                valid_q  <= 1'b0;
            end else begin
                valid_q  <= valid_q;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.out_valid = valid_q;
    assign bus.fc_result = result_q;
endmodule
